// File: rtl/dram_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data DRAM access controller.
package dram_access_ctrl_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [0:0] {
        IDLE,
        RMW_WR
    } state_e;

endpackage

// File: rtl/dram_access_ctrl_if.sv
// CPU (MEM stage) and debug/trace request bundle seen by the DRAM access controller.
interface dram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    import dram_access_ctrl_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic              cpu_sext;
    logic [31:0]       cpu_adr;
    logic [WORD_W-1:0] cpu_wdata;
    logic [WORD_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              cpu_misalign;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_adr;
    logic [WORD_W-1:0] dbg_wdata;
    logic [WORD_W-1:0] dbg_rdata;
    logic              dbg_gnt;

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_sext, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_misalign,
        output dbg_req, dbg_we, dbg_adr, dbg_wdata,
        input  dbg_rdata, dbg_gnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_sext, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_misalign,
        input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
        output dbg_rdata, dbg_gnt
    );

endinterface

// File: rtl/dram_access_ctrl_mem_lane_unit.sv
// Byte-lane datapath: load extract/extend from a DRAM word, and sub-word store merge.
module mem_lane_unit
    import dram_access_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] ld_word,
    input  logic [1:0]        ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_sext,
    output logic [WORD_W-1:0] ld_data,

    input  logic [WORD_W-1:0] st_word,
    input  logic [1:0]        st_off,
    input  logic              st_byte,
    input  logic [15:0]       st_data,
    output logic [WORD_W-1:0] st_merged
);

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Halves are only ever extracted aligned, so lane select uses off[1] alone.
    assign ld_b = ld_word[{ld_off, 3'b000} +: 8];
    assign ld_h = ld_word[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_sext & ld_b[7]}}, ld_b};
            SZ_H:    ld_data = {{16{ld_sext & ld_h[15]}}, ld_h};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_merged = st_word;
        if (st_byte) begin
            st_merged[{st_off, 3'b000} +: 8] = st_data[7:0];
        end else begin
            st_merged[{st_off[1], 4'b0000} +: 16] = st_data;
        end
    end

endmodule

// File: rtl/dram_access_ctrl.sv
// MEM-stage data DRAM controller: word/sub-word loads and stores (sub-word stores via
// read-modify-write) with a debug port that takes priority whenever the FSM is idle.
module dram_access_ctrl
    import dram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter bit          DBG_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    dram_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] dram_a,
    output logic              dram_we,
    output logic [WORD_W-1:0] dram_d,
    input  logic [WORD_W-1:0] dram_spo
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] hold_adr_q, hold_adr_d;
    logic [WORD_W-1:0] hold_word_q, hold_word_d;
    logic [1:0]        hold_off_q, hold_off_d;
    logic              hold_byte_q, hold_byte_d;
    logic [15:0]       hold_data_q, hold_data_d;

    logic              is_word;
    logic              misalign;
    logic              dbg_act;
    logic [WORD_W-1:0] ld_data;
    logic [WORD_W-1:0] st_merged;
    logic              unused_adr_hi;

    assign unused_adr_hi = ^bus.cpu_adr[31:ADDR_W+2];

    // Size 2'b11 falls in with word accesses.
    assign is_word  = bus.cpu_size[1];
    assign misalign = ((bus.cpu_size == SZ_H) && bus.cpu_adr[0]) ||
                      (is_word && (bus.cpu_adr[1:0] != 2'b00));
    assign dbg_act  = DBG_EN && bus.dbg_req && (state_q == IDLE);

    assign bus.dbg_rdata = dram_spo;

    mem_lane_unit u_lane (
        .ld_word   (dram_spo),
        .ld_off    (bus.cpu_adr[1:0]),
        .ld_size   (bus.cpu_size),
        .ld_sext   (bus.cpu_sext),
        .ld_data   (ld_data),
        .st_word   (hold_word_q),
        .st_off    (hold_off_q),
        .st_byte   (hold_byte_q),
        .st_data   (hold_data_q),
        .st_merged (st_merged)
    );

    always_comb begin
        state_d          = state_q;
        hold_adr_d       = hold_adr_q;
        hold_word_d      = hold_word_q;
        hold_off_d       = hold_off_q;
        hold_byte_d      = hold_byte_q;
        hold_data_d      = hold_data_q;
        dram_a           = bus.cpu_adr[ADDR_W+1:2];
        dram_we          = 1'b0;
        dram_d           = bus.cpu_wdata;
        bus.cpu_rdata    = '0;
        bus.cpu_ready    = 1'b0;
        bus.cpu_misalign = 1'b0;
        bus.dbg_gnt      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dbg_act) begin
                    bus.dbg_gnt = 1'b1;
                    dram_a      = bus.dbg_adr;
                    dram_we     = bus.dbg_we;
                    dram_d      = bus.dbg_wdata;
                end else if (bus.cpu_req) begin
                    if (misalign) begin
                        bus.cpu_ready    = 1'b1;
                        bus.cpu_misalign = 1'b1;
                    end else if (!bus.cpu_we) begin
                        bus.cpu_ready = 1'b1;
                        bus.cpu_rdata = ld_data;
                    end else if (is_word) begin
                        bus.cpu_ready = 1'b1;
                        dram_we       = 1'b1;
                    end else begin
                        // Capture everything now; the write cycle must not depend on CPU inputs.
                        hold_adr_d  = bus.cpu_adr[ADDR_W+1:2];
                        hold_word_d = dram_spo;
                        hold_off_d  = bus.cpu_adr[1:0];
                        hold_byte_d = (bus.cpu_size == SZ_B);
                        hold_data_d = bus.cpu_wdata[15:0];
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                dram_a        = hold_adr_q;
                dram_we       = 1'b1;
                dram_d        = st_merged;
                bus.cpu_ready = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            dram_we          = 1'b0;
            bus.cpu_ready    = 1'b0;
            bus.cpu_misalign = 1'b0;
            bus.dbg_gnt      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_adr_q  <= '0;
            hold_word_q <= '0;
            hold_off_q  <= '0;
            hold_byte_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_adr_q  <= hold_adr_d;
            hold_word_q <= hold_word_d;
            hold_off_q  <= hold_off_d;
            hold_byte_q <= hold_byte_d;
            hold_data_q <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Self-checking bench for dram_access_ctrl with a behavioural DRAM and a result scoreboard.
module tb_dram_access_ctrl;
    import dram_access_ctrl_pkg::*;

    localparam int unsigned ADDR_W = 14;

    typedef struct {
        logic        chk_rdata;
        logic        is_store;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] wword;
        int          cycles;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] dram_a;
    logic              dram_we;
    logic [31:0]       dram_d;
    logic [31:0]       dram_spo;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    int                n_tests = 0;
    int                n_fail = 0;
    int                cyc_cnt = 0;
    exp_t              exp_q[$];

    dram_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dram_access_ctrl #(.ADDR_W(ADDR_W), .DBG_EN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dram_a   (dram_a),
        .dram_we  (dram_we),
        .dram_d   (dram_d),
        .dram_spo (dram_spo)
    );

    always #5 clk = ~clk;

    assign dram_spo = mem[dram_a];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (dram_we) mem[dram_a] <= dram_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] adr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic [31:0] exp_ww,
                         input logic mis, input int cycles);
        exp_t e;
        e.chk_rdata = !we || mis;
        e.is_store  = we;
        e.mis       = mis;
        e.rdata     = exp_rd;
        e.wword     = exp_ww;
        e.cycles    = cycles;
        exp_q.push_back(e);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_size  = size;
        bus.cpu_sext  = sext;
        bus.cpu_adr   = adr;
        bus.cpu_wdata = wd;
    endtask

    task automatic complete(input string tag);
        exp_t e;
        int   cyc;
        logic done;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e    = exp_q.pop_front();
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_ready) begin
                done = 1'b1;
                check({tag, " misalign"}, 32'(bus.cpu_misalign), 32'(e.mis));
                check({tag, " dbg_gnt"}, 32'(bus.dbg_gnt), 32'd0);
                if (e.chk_rdata) check({tag, " rdata"}, bus.cpu_rdata, e.rdata);
                if (e.mis) begin
                    check({tag, " no write"}, 32'(dram_we), 32'd0);
                end else if (e.is_store) begin
                    check({tag, " we"}, 32'(dram_we), 32'd1);
                    check({tag, " dram_d"}, dram_d, e.wword);
                end
            end else begin
                check({tag, " stall we"}, 32'(dram_we), 32'd0);
            end
        end
        check({tag, " cycles"}, 32'(cyc), 32'(e.cycles));
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input string tag, input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [31:0] exp_ww,
                          input logic mis, input int cycles);
        issue(we, size, sext, adr, wd, exp_rd, exp_ww, mis, cycles);
        complete(tag);
    endtask

    task automatic dbg_op(input string tag, input logic we, input logic [ADDR_W-1:0] adr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_adr   = adr;
        bus.dbg_wdata = wd;
        @(negedge clk);
        check({tag, " gnt"}, 32'(bus.dbg_gnt), 32'd1);
        if (!we) check({tag, " rdata"}, bus.dbg_rdata, exp_rd);
        @(posedge clk);
        #1;
        bus.dbg_req = 1'b0;
    endtask

    initial begin
        int t0;
        rst           = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_size  = SZ_W;
        bus.cpu_sext  = 1'b0;
        bus.cpu_adr   = 32'h0;
        bus.cpu_wdata = 32'hFFFF_FFFF;
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_adr   = '0;
        bus.dbg_wdata = 32'h0;

        // Outputs forced quiet while reset is held, even with both requesters active.
        @(negedge clk);
        check("reset ready", 32'(bus.cpu_ready), 32'd0);
        check("reset misalign", 32'(bus.cpu_misalign), 32'd0);
        check("reset gnt", 32'(bus.dbg_gnt), 32'd0);
        check("reset we", 32'(dram_we), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;

        cpu_op("sw", 1'b1, SZ_W, 1'b0, 32'h10, 32'h1234_5678, '0, 32'h1234_5678, 1'b0, 1);
        cpu_op("lw", 1'b0, SZ_W, 1'b0, 32'h10, '0, 32'h1234_5678, '0, 1'b0, 1);

        dbg_op("pre 0x20", 1'b1, 14'd8, 32'hAABB_CCDD, '0);
        cpu_op("sb 0x21", 1'b1, SZ_B, 1'b0, 32'h21, 32'h0000_00EE, '0, 32'hAABB_EEDD, 1'b0, 2);
        cpu_op("sh 0x22", 1'b1, SZ_H, 1'b0, 32'h22, 32'h0000_1234, '0, 32'h1234_EEDD, 1'b0, 2);
        cpu_op("lw 0x20", 1'b0, SZ_W, 1'b0, 32'h20, '0, 32'h1234_EEDD, '0, 1'b0, 1);

        dbg_op("pre 0x24", 1'b1, 14'd9, 32'h0, '0);
        t0 = cyc_cnt;
        cpu_op("b2b sb0", 1'b1, SZ_B, 1'b0, 32'h24, 32'hFFFF_FF11, '0, 32'h0000_0011, 1'b0, 2);
        cpu_op("b2b sb1", 1'b1, SZ_B, 1'b0, 32'h25, 32'h0000_0022, '0, 32'h0000_2211, 1'b0, 2);
        cpu_op("b2b sh", 1'b1, SZ_H, 1'b0, 32'h26, 32'hFFFF_BEEF, '0, 32'hBEEF_2211, 1'b0, 2);
        check("b2b total cycles", 32'(cyc_cnt - t0), 32'd6);
        dbg_op("rd 0x24", 1'b0, 14'd9, '0, 32'hBEEF_2211);

        dbg_op("pre 0x30", 1'b1, 14'd12, 32'h80FF_7F01, '0);
        cpu_op("lb 0x31", 1'b0, SZ_B, 1'b1, 32'h31, '0, 32'h0000_007F, '0, 1'b0, 1);
        cpu_op("lb 0x32", 1'b0, SZ_B, 1'b1, 32'h32, '0, 32'hFFFF_FFFF, '0, 1'b0, 1);
        cpu_op("lbu 0x33", 1'b0, SZ_B, 1'b0, 32'h33, '0, 32'h0000_0080, '0, 1'b0, 1);
        cpu_op("lh 0x32", 1'b0, SZ_H, 1'b1, 32'h32, '0, 32'hFFFF_80FF, '0, 1'b0, 1);
        cpu_op("lhu 0x30", 1'b0, SZ_H, 1'b0, 32'h30, '0, 32'h0000_7F01, '0, 1'b0, 1);
        cpu_op("lw sz3 0x30", 1'b0, 2'b11, 1'b1, 32'h30, '0, 32'h80FF_7F01, '0, 1'b0, 1);

        dbg_op("pre 0x40", 1'b1, 14'd16, 32'h1111_1111, '0);
        cpu_op("lw 0x42 mis", 1'b0, SZ_W, 1'b0, 32'h42, '0, 32'h0, '0, 1'b1, 1);
        cpu_op("sh 0x43 mis", 1'b1, SZ_H, 1'b0, 32'h43, 32'h0000_FFFF, 32'h0, '0, 1'b1, 1);
        cpu_op("sw 0x41 mis", 1'b1, SZ_W, 1'b0, 32'h41, 32'h2222_2222, 32'h0, '0, 1'b1, 1);
        dbg_op("rd 0x40", 1'b0, 14'd16, '0, 32'h1111_1111);

        // Debug write contends with a CPU load of the same word; debug goes first.
        issue(1'b0, SZ_W, 1'b0, 32'h14, '0, 32'hDEAD_BEEF, '0, 1'b0, 1);
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_adr   = 14'd5;
        bus.dbg_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("arb gnt", 32'(bus.dbg_gnt), 32'd1);
        check("arb cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("arb we", 32'(dram_we), 32'd1);
        check("arb dram_a", 32'(dram_a), 32'd5);
        @(posedge clk);
        #1;
        bus.dbg_req = 1'b0;
        complete("arb lw");

        // Debug arriving during RMW_WR waits for the write to finish.
        dbg_op("pre 0x18", 1'b1, 14'd6, 32'h0102_0304, '0);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_size  = SZ_B;
        bus.cpu_adr   = 32'h18;
        bus.cpu_wdata = 32'h0000_00AA;
        @(negedge clk);
        check("rmwdbg c0 ready", 32'(bus.cpu_ready), 32'd0);
        check("rmwdbg c0 we", 32'(dram_we), 32'd0);
        @(posedge clk);
        #1;
        bus.dbg_req = 1'b1;
        bus.dbg_we  = 1'b0;
        bus.dbg_adr = 14'd6;
        @(negedge clk);
        check("rmwdbg c1 gnt", 32'(bus.dbg_gnt), 32'd0);
        check("rmwdbg c1 ready", 32'(bus.cpu_ready), 32'd1);
        check("rmwdbg c1 dram_d", dram_d, 32'h0102_03AA);
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rmwdbg c2 gnt", 32'(bus.dbg_gnt), 32'd1);
        check("rmwdbg c2 rdata", bus.dbg_rdata, 32'h0102_03AA);
        @(posedge clk);
        #1;
        bus.dbg_req = 1'b0;

        // Reset during the RMW write cycle must abandon the write.
        dbg_op("pre 0x50", 1'b1, 14'd20, 32'h5566_7788, '0);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_size  = SZ_B;
        bus.cpu_adr   = 32'h50;
        bus.cpu_wdata = 32'h0000_0099;
        @(negedge clk);
        check("rstrmw c0 ready", 32'(bus.cpu_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrmw we", 32'(dram_we), 32'd0);
        check("rstrmw ready", 32'(bus.cpu_ready), 32'd0);
        check("rstrmw gnt", 32'(bus.dbg_gnt), 32'd0);
        check("rstrmw misalign", 32'(bus.cpu_misalign), 32'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.cpu_req = 1'b0;
        dbg_op("rstrmw rd", 1'b0, 14'd20, '0, 32'h5566_7788);
        cpu_op("rstrmw lw idle", 1'b0, SZ_W, 1'b0, 32'h50, '0, 32'h5566_7788, '0, 1'b0, 1);

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
